// File: rtl/vid_palette_banked.sv
// Multi-bank video palette: host/fill writes go to the shadow bank, pixel lookups read the
// active bank with a fixed two-cycle latency, and bank swaps happen only on frame boundaries.
module vid_palette_banked #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 8,
    parameter int unsigned BANKS = 2,
    localparam int unsigned BW   = $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] w_addr_0,
    input  logic [DW-1:0] w_data_0,
    input  logic          w_ena_0,
    input  logic          fill_req,
    input  logic [DW-1:0] fill_data,
    output logic          fill_busy,
    input  logic          swap_req,
    input  logic          frame_sync,
    output logic          swap_pending,
    output logic [BW-1:0] active_bank,
    input  logic [AW-1:0] r_addr_0,
    input  logic          r_ena_0,
    output logic [DW-1:0] r_data_2,
    output logic          r_valid_2
);

    localparam int unsigned WORDS = BANKS * (2 ** AW);

    typedef enum logic [0:0] {StIdle, StFill} fill_state_e;

    fill_state_e      state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    fill_data_q, fill_data_d;
    logic [BW-1:0]    active_q, active_d;
    logic [BW-1:0]    shadow;
    logic             pending_q, pending_d;
    logic             swap_go;

    logic             we;
    logic [BW+AW-1:0] waddr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    mem [WORDS];

    logic             rd_ena_q;
    logic [BW+AW-1:0] rd_addr_q;

    // Power-of-two bank count makes the natural wrap the modulo.
    assign shadow       = active_q + 1'b1;
    assign fill_busy    = (state_q == StFill);
    assign swap_pending = pending_q;
    assign active_bank  = active_q;

    // Fill engine and write-port arbitration; the host write wins and stalls the fill.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_data_d = fill_data_q;
        we          = w_ena_0;
        waddr       = {shadow, w_addr_0};
        wdata       = w_data_0;
        case (state_q)
            StIdle: begin
                if (fill_req) begin
                    state_d     = StFill;
                    cnt_d       = '0;
                    fill_data_d = fill_data;
                end
            end
            StFill: begin
                if (!w_ena_0) begin
                    we    = 1'b1;
                    waddr = {shadow, cnt_q};
                    wdata = fill_data_q;
                    if (cnt_q == '1) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        swap_go   = frame_sync & pending_q & (state_q == StIdle);
        active_d  = swap_go ? shadow : active_q;
        pending_d = swap_go ? 1'b0 : (pending_q | swap_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fill_data_q <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_data_q <= fill_data_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Bank is captured with the address at issue, so a swap cannot redirect an in-flight lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ena_q  <= 1'b0;
            rd_addr_q <= '0;
            r_valid_2 <= 1'b0;
            r_data_2  <= '0;
        end else begin
            rd_ena_q  <= r_ena_0;
            if (r_ena_0) begin
                rd_addr_q <= {active_q, r_addr_0};
            end
            r_valid_2 <= rd_ena_q;
            if (rd_ena_q) begin
                r_data_2 <= mem[rd_addr_q];
            end
        end
    end

endmodule

// File: tb/tb_vid_palette_banked.sv
// Randomised and directed bench for vid_palette_banked with a bank-level reference model and
// a scoreboard monitor that checks lookups, swap state and fill duration.
module tb_vid_palette_banked;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned BANKS = 4;
    localparam int unsigned BW    = 2;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] w_addr_0 = '0;
    logic [DW-1:0] w_data_0 = '0;
    logic          w_ena_0 = 1'b0;
    logic          fill_req = 1'b0;
    logic [DW-1:0] fill_data = '0;
    logic          fill_busy;
    logic          swap_req = 1'b0;
    logic          frame_sync = 1'b0;
    logic          swap_pending;
    logic [BW-1:0] active_bank;
    logic [AW-1:0] r_addr_0 = '0;
    logic          r_ena_0 = 1'b0;
    logic [DW-1:0] r_data_2;
    logic          r_valid_2;

    always #5 clk = ~clk;

    vid_palette_banked #(
        .DW   (DW),
        .AW   (AW),
        .BANKS(BANKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_addr_0    (w_addr_0),
        .w_data_0    (w_data_0),
        .w_ena_0     (w_ena_0),
        .fill_req    (fill_req),
        .fill_data   (fill_data),
        .fill_busy   (fill_busy),
        .swap_req    (swap_req),
        .frame_sync  (frame_sync),
        .swap_pending(swap_pending),
        .active_bank (active_bank),
        .r_addr_0    (r_addr_0),
        .r_ena_0     (r_ena_0),
        .r_data_2    (r_data_2),
        .r_valid_2   (r_valid_2)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem   [BANKS][DEPTH];
    bit            m_known [BANKS][DEPTH];
    int            m_active;
    bit            m_pending;
    bit            m_filling;
    int            m_cnt;
    logic [DW-1:0] m_fdata;
    int            cyc = 0;
    int            exp_busy_len = 0;

    int            n_checks = 0;
    int            n_pass = 0;

    // Reference model: palette banks as arrays, updated once per rising edge from the rules.
    always @(posedge clk or negedge rst_n) begin
        int  sh;
        bit  was_busy;
        if (!rst_n) begin
            m_active  = 0;
            m_pending = 0;
            m_filling = 0;
            m_cnt     = 0;
            for (int b = 0; b < BANKS; b++)
                for (int a = 0; a < DEPTH; a++) m_known[b][a] = 0;
        end else begin
            cyc++;
            sh       = (m_active + 1) % BANKS;
            was_busy = m_filling;
            if (r_ena_0)
                exp_q.push_back('{data: m_mem[m_active][r_addr_0],
                                  known: m_known[m_active][r_addr_0], due: cyc + 1});
            if (w_ena_0) begin
                m_mem[sh][w_addr_0]   = w_data_0;
                m_known[sh][w_addr_0] = 1;
            end else if (m_filling) begin
                m_mem[sh][m_cnt]   = m_fdata;
                m_known[sh][m_cnt] = 1;
                if (m_cnt == DEPTH - 1) m_filling = 0;
                else m_cnt++;
            end
            if (!was_busy && fill_req) begin
                m_filling = 1;
                m_cnt     = 0;
                m_fdata   = fill_data;
            end
            if (frame_sync && m_pending && !was_busy) begin
                m_active  = (m_active + 1) % BANKS;
                m_pending = 0;
            end else if (swap_req) begin
                m_pending = 1;
            end
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    // Monitor: consumes expected lookups as the DUT presents them.
    int            rd = 0;
    int            run = 0;
    logic [DW-1:0] last = '0;

    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            #1;
            check("rst_active_bank", active_bank, 0);
            check("rst_swap_pending", swap_pending, 0);
            check("rst_fill_busy", fill_busy, 0);
            check("rst_r_valid_2", r_valid_2, 0);
            check("rst_r_data_2", r_data_2, 0);
            rd   = exp_q.size();
            run  = 0;
            last = '0;
        end else begin
            check("active_bank", active_bank, m_active);
            check("swap_pending", swap_pending, m_pending);
            check("fill_busy", fill_busy, m_filling);
            if (r_valid_2) begin
                if (rd >= exp_q.size()) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: r_valid_2=1, required 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q[rd];
                    rd++;
                    check("lookup_latency", cyc, e.due);
                    if (e.known) check("r_data_2", r_data_2, e.data);
                end
                last = r_data_2;
            end else begin
                if (rd < exp_q.size()) check("valid_overdue", exp_q[rd].due <= cyc, 0);
                check("r_data_hold", r_data_2, last);
            end
            if (fill_busy) begin
                run++;
            end else begin
                if (run > 0 && exp_busy_len > 0) check("fill_busy_len", run, exp_busy_len);
                run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        fill_req   = 1'b0;
        swap_req   = 1'b0;
        frame_sync = 1'b0;
        w_ena_0    = 1'b0;
        r_ena_0    = 1'b0;
    endtask

    task automatic wait_fill_done();
        int t = 0;
        while (fill_busy && t < 400) begin
            step();
            t++;
        end
        if (fill_busy) begin
            $display("FAIL fill_timeout: fill_busy=1 after %0d cycles, required 0", t);
            $fatal(1, "fill engine did not finish");
        end
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        frame_sync = 1'b1;
        step();
    endtask

    task automatic fill_with_host(input int delay);
        exp_busy_len = 266;
        fill_req  = 1'b1;
        fill_data = 16'hF800;
        step();
        repeat (delay) step();
        for (int i = 0; i < 10; i++) begin
            w_ena_0  = 1'b1;
            w_addr_0 = 8'd3;
            w_data_0 = 16'h0001;
            step();
        end
        wait_fill_done();
        do_swap();
        r_ena_0  = 1'b1;
        r_addr_0 = 8'd3;
        step();
        repeat (3) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single host write then swap; lookup of entry 5.
        w_ena_0  = 1'b1;
        w_addr_0 = 8'd5;
        w_data_0 = 16'h1234;
        step();
        do_swap();
        r_ena_0  = 1'b1;
        r_addr_0 = 8'd5;
        step();
        repeat (3) step();

        // Uninterrupted fill of the whole shadow bank, then read every entry back.
        exp_busy_len = 256;
        fill_req  = 1'b1;
        fill_data = 16'hF800;
        step();
        wait_fill_done();
        do_swap();
        for (int i = 0; i < DEPTH; i++) begin
            r_ena_0  = 1'b1;
            r_addr_0 = AW'(i);
            step();
        end
        repeat (3) step();

        // Host writes to entry 3 before and after the fill passes it.
        fill_with_host(0);
        fill_with_host(20);

        // Swap request during a fill is held until the first frame_sync after it ends.
        exp_busy_len = 256;
        fill_req  = 1'b1;
        fill_data = 16'h07E0;
        step();
        swap_req = 1'b1;
        step();
        repeat (50) step();
        frame_sync = 1'b1;
        step();
        wait_fill_done();
        repeat (5) step();
        frame_sync = 1'b1;
        step();

        // Back-to-back lookups straddling a swap.
        swap_req = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            r_ena_0    = 1'b1;
            r_addr_0   = AW'(i * 37);
            frame_sync = (i == 3);
            step();
        end
        repeat (3) step();

        // Random traffic.
        exp_busy_len = 0;
        for (int i = 0; i < 3000; i++) begin
            r_ena_0    = ($urandom_range(0, 1) == 1);
            r_addr_0   = AW'($urandom);
            w_ena_0    = ($urandom_range(0, 3) == 0);
            w_addr_0   = AW'($urandom);
            w_data_0   = DW'($urandom);
            fill_req   = ($urandom_range(0, 199) == 0);
            fill_data  = DW'($urandom);
            swap_req   = ($urandom_range(0, 19) == 0);
            frame_sync = ($urandom_range(0, 29) == 0);
            step();
        end
        wait_fill_done();
        repeat (4) step();

        // Reset mid-fill with a swap pending and lookups in flight.
        fill_req  = 1'b1;
        fill_data = 16'hAAAA;
        step();
        repeat (20) step();
        swap_req = 1'b1;
        step();
        r_ena_0  = 1'b1;
        r_addr_0 = 8'd9;
        step();
        r_ena_0  = 1'b1;
        r_addr_0 = 8'd10;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        r_ena_0 = 1'b0;
        rst_n   = 1'b1;
        frame_sync = 1'b1;
        step();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vid_palette_banked.md
VID_PALETTE_BANKED -- requirements
Module: vid_palette_banked

Interface
REQ-001 SHALL have parameter DW, default 16, palette entry width in bits.
REQ-002 SHALL have parameter AW, default 8, palette index width; depth = 2^AW entries per bank.
REQ-003 SHALL have parameter BANKS, default 2, number of palette banks; power of two, >= 2; BW = log2(BANKS).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports w_addr_0  in  AW, w_data_0  in  DW, w_ena_0  in  1: host write to shadow bank.
REQ-007 SHALL have ports fill_req  in  1 (pulse), fill_data  in  DW: start fill of whole shadow bank with fill_data.
REQ-008 SHALL have port fill_busy  out  1  fill engine running.
REQ-009 SHALL have ports swap_req  in  1 (pulse), frame_sync  in  1 (frame-boundary strobe).
REQ-010 SHALL have ports swap_pending  out  1, active_bank  out  BW.
REQ-011 SHALL have ports r_addr_0  in  AW, r_ena_0  in  1, r_data_2  out  DW, r_valid_2  out  1: pixel lookup.

Function
REQ-012 SHALL implement storage as BANKS x 2^AW x DW inferred synchronous RAM, one write port, one read port.
REQ-013 Shadow bank SHALL be (active_bank + 1) mod BANKS; all writes (host or fill) target shadow bank only.
REQ-014 Lookup SHALL have fixed latency 2: r_ena_0 at cycle N -> r_data_2 = active-bank[r_addr_0] (bank sampled at cycle N) and r_valid_2 = 1 at cycle N+2.
REQ-015 r_valid_2 SHALL be 0 in any cycle whose N-2 had r_ena_0 = 0; r_data_2 SHALL hold its last value then.
REQ-016 Fill FSM states: IDLE, FILL. IDLE->FILL on fill_req (latch fill_data, counter = 0); FILL->IDLE after writing entry 2^AW-1.
REQ-017 In FILL, one entry written per cycle; when w_ena_0 = 1 the host write SHALL win that cycle and the fill counter SHALL stall.
REQ-018 fill_req while fill_busy = 1 SHALL be ignored; fill_busy = 1 exactly while in FILL.
REQ-019 swap_req SHALL set swap_pending; swap_req while swap_pending = 1 has no effect.
REQ-020 On frame_sync with swap_pending = 1 and fill_busy = 0: active_bank increments mod BANKS and swap_pending clears, both visible next cycle.
REQ-021 frame_sync with swap_pending = 1 and fill_busy = 1 SHALL not swap; swap deferred to next qualifying frame_sync.
REQ-022 swap_req and frame_sync in same cycle with swap_pending = 0 SHALL only set swap_pending; no swap that cycle.
REQ-023 A swap SHALL not corrupt in-flight lookups (REQ-014 bank sampling); active_bank wraps BANKS-1 -> 0.
REQ-024 Host write to shadow bank in the swap cycle SHALL land in the pre-swap shadow bank (new active bank).

Reset
REQ-025 rst_n low SHALL asynchronously force active_bank = 0, swap_pending = 0, fill_busy = 0 (FSM IDLE, counter 0), r_valid_2 = 0, r_data_2 = 0.
REQ-026 Reset mid-fill SHALL abort fill; RAM contents SHALL be undefined after reset and not cleared.

Verification
REQ-027 Write shadow[5] = 16'h1234, swap_req, frame_sync -> active_bank = 1 next cycle; r_ena_0 with r_addr_0 = 5 -> r_data_2 = 16'h1234, r_valid_2 = 1 two cycles later.
REQ-028 fill_req with fill_data = 16'hF800, AW = 8, no host writes -> fill_busy high exactly 256 cycles; after swap all 256 lookups return 16'hF800.
REQ-029 During fill, w_ena_0 high 10 cycles at addr 3 = 16'h0001 -> fill_busy lasts 266 cycles; post-swap entry 3 = 16'hF800 if fill passed 3 after, else 16'h0001 (check both orderings).
REQ-030 swap_req during fill, frame_sync mid-fill -> no swap, swap_pending stays 1; first frame_sync after fill_busy falls -> swap.
REQ-031 BANKS = 4, four swaps -> active_bank 1,2,3,0; back-to-back r_ena_0 across a swap -> each r_data_2 from bank sampled at its issue cycle.
REQ-032 rst_n low mid-fill and with swap_pending = 1 -> all outputs at REQ-025 values immediately, no swap on next frame_sync.
